// File: rtl/transition_buffer_if.sv
`default_nettype none
// ==========================================================================
// Module  : transition_buffer_if
// Purpose : producer-side and consumer-side tuple streams of transition_buffer
// Rev     : 1.0  initial release
// ==========================================================================
interface transition_buffer_if #(
  parameter int STATES_WIDTH  = 8,
  parameter int ACTIONS_WIDTH = 2,
  parameter int DATA_WIDTH    = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [STATES_WIDTH-1:0]  in_state;
  logic [STATES_WIDTH-1:0]  in_next_state;
  logic [ACTIONS_WIDTH-1:0] in_action;
  logic [DATA_WIDTH-1:0]    in_reward;

  logic                     out_valid;
  logic                     out_ready;
  logic [STATES_WIDTH-1:0]  out_state;
  logic [STATES_WIDTH-1:0]  out_next_state;
  logic [ACTIONS_WIDTH-1:0] out_action;
  logic [DATA_WIDTH-1:0]    out_reward;

  modport master (
    output in_valid, in_state, in_next_state, in_action, in_reward, out_ready,
    input  in_ready, out_valid, out_state, out_next_state, out_action, out_reward
  );

  modport slave (
    input  in_valid, in_state, in_next_state, in_action, in_reward, out_ready,
    output in_ready, out_valid, out_state, out_next_state, out_action, out_reward
  );
endinterface
`default_nettype wire

// File: rtl/transition_buffer.sv
`default_nettype none
// ==========================================================================
// Module  : transition_buffer
// Purpose : FWFT FIFO of Q-learning transition tuples with RUN/DRAIN/DONE
//           end-of-episode control; TRANSITION_BUFFER_STATS_EN adds counters
// Rev     : 1.0  initial release
// ==========================================================================
module transition_buffer #(
  parameter int  STATES_WIDTH  = 8,
  parameter int  ACTIONS_WIDTH = 2,
  parameter int  DATA_WIDTH    = 16,
  parameter int  DEPTH         = 16,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  transition_buffer_if.slave   bus,
  input  wire logic            stop,
  input  wire logic            start,
  output logic                 done,
  output logic [ADDR_WIDTH:0]  count
`ifdef TRANSITION_BUFFER_STATS_EN
  ,
  output logic [15:0]          accepted_cnt,
  output logic [15:0]          delivered_cnt
`endif
);

  localparam int                  c_TUPLE_W   = 2*STATES_WIDTH + ACTIONS_WIDTH + DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] c_CNT_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_PTR_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_wr_ptr;
  logic [ADDR_WIDTH-1:0]  r_rd_ptr;
  logic [ADDR_WIDTH:0]    r_count;
  logic [c_TUPLE_W-1:0]   r_mem [DEPTH];

  logic                   w_full;
  logic                   w_in_ready;
  logic                   w_out_valid;
  logic                   w_done;
  logic                   w_push;
  logic                   w_pop;
  logic [c_TUPLE_W-1:0]   w_in_tuple;

  assign w_full      = (r_count == c_DEPTH_CNT);
  assign w_out_valid = (r_count != '0);
  assign w_push      = bus.in_valid && w_in_ready;
  assign w_pop       = w_out_valid && bus.out_ready;
  assign w_in_tuple  = {bus.in_state, bus.in_next_state, bus.in_action, bus.in_reward};

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_RUN: begin
        // stop masks in_ready in the same cycle so a coincident tuple is refused
        w_in_ready = !w_full && !stop;
        if (stop) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (r_count == '0) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done = 1'b1;
        if (start) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_RUN;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; validity is carried by r_count alone.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_tuple;
  end

  assign {bus.out_state, bus.out_next_state, bus.out_action, bus.out_reward} = r_mem[r_rd_ptr];
  assign bus.out_valid = w_out_valid;
  assign bus.in_ready  = w_in_ready;
  assign done          = w_done;
  assign count         = r_count;

`ifdef TRANSITION_BUFFER_STATS_EN
  logic [15:0] r_acc_cnt;
  logic [15:0] r_del_cnt;
  logic        w_stats_clr;

  assign w_stats_clr = (r_state == ST_DONE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_cnt <= '0;
      r_del_cnt <= '0;
    end else if (w_stats_clr) begin
      r_acc_cnt <= '0;
      r_del_cnt <= '0;
    end else begin
      if (w_push && (r_acc_cnt != 16'hFFFF)) r_acc_cnt <= r_acc_cnt + 16'd1;
      if (w_pop  && (r_del_cnt != 16'hFFFF)) r_del_cnt <= r_del_cnt + 16'd1;
    end
  end

  assign accepted_cnt  = r_acc_cnt;
  assign delivered_cnt = r_del_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_transition_buffer.sv
`default_nettype none
// ==========================================================================
// Module  : tb_transition_buffer
// Purpose : randomized self-checking bench for transition_buffer (queue model)
// Rev     : 1.0  initial release
// ==========================================================================
module tb_transition_buffer;
  localparam int SW    = 8;
  localparam int AW    = 2;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int TW    = 2*SW + AW + DW;

  localparam int P_RUN   = 0;
  localparam int P_DRAIN = 1;
  localparam int P_DONE  = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        stop  = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [4:0]  count;
  logic [15:0] acc_cnt;
  logic [15:0] del_cnt;

  transition_buffer_if #(.STATES_WIDTH(SW), .ACTIONS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  transition_buffer #(
    .STATES_WIDTH(SW), .ACTIONS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .stop  (stop),
    .start (start),
    .done  (done),
    .count (count)
`ifdef TRANSITION_BUFFER_STATS_EN
    ,
    .accepted_cnt  (acc_cnt),
    .delivered_cnt (del_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of tuples plus the episode phase.
  logic [TW-1:0] q[$];
  int            m_phase = P_RUN;
  int            m_acc   = 0;
  int            m_del   = 0;
  int            checks   = 0;
  int            failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [TW-1:0] mk(input int i);
    logic [SW-1:0] s, n;
    logic [AW-1:0] a;
    logic [DW-1:0] r;
    s = SW'(i);
    n = SW'(i + 1);
    a = AW'(i % 4);
    r = DW'(-i);
    return {s, n, a, r};
  endfunction

  function automatic logic [TW-1:0] rnd_tup();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[TW-1:0];
  endfunction

  task automatic cycle(input logic iv, input logic ordy, input logic stp, input logic strt,
                       input logic [TW-1:0] tup);
    logic exp_ir, exp_ov, push, pop;
    int   nxt;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    stop          = stp;
    start         = strt;
    {bus.in_state, bus.in_next_state, bus.in_action, bus.in_reward} = tup;
    #1;
    exp_ir = (m_phase == P_RUN) && (q.size() < DEPTH) && !stp;
    exp_ov = (q.size() != 0);
    check_val("in_ready",  64'(bus.in_ready),  64'(exp_ir));
    check_val("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    check_val("count",     64'(count),         64'(q.size()));
    check_val("done",      64'(done),          64'(m_phase == P_DONE));
    if (exp_ov)
      check_val("head", 64'({bus.out_state, bus.out_next_state, bus.out_action, bus.out_reward}),
                64'(q[0]));
`ifdef TRANSITION_BUFFER_STATS_EN
    check_val("accepted_cnt",  64'(acc_cnt), 64'(m_acc));
    check_val("delivered_cnt", 64'(del_cnt), 64'(m_del));
`endif
    push = iv && exp_ir;
    pop  = exp_ov && ordy;
    nxt  = m_phase;
    case (m_phase)
      P_RUN:   if (stp) nxt = P_DRAIN;
      P_DRAIN: if (q.size() == 0) nxt = P_DONE;
      P_DONE:  if (strt) nxt = P_RUN;
      default: nxt = P_RUN;
    endcase
    @(posedge clk);
    if (m_phase == P_DONE && strt) begin
      m_acc = 0;
      m_del = 0;
    end else begin
      if (push && m_acc < 65535) m_acc++;
      if (pop  && m_del < 65535) m_del++;
    end
    m_phase = nxt;
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(tup);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    stop          = 1'b0;
    start         = 1'b0;
    rst_n         = 1'b0;
    #1;
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_count",     64'(count),         64'd0);
    check_val("rst_done",      64'(done),          64'd0);
    check_val("rst_in_ready",  64'(bus.in_ready),  64'd1);
    q.delete();
    m_phase = P_RUN;
    m_acc   = 0;
    m_del   = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    {bus.in_state, bus.in_next_state, bus.in_action, bus.in_reward} = '0;
    repeat (2) @(negedge clk);
    #1;
    check_val("reset_in_ready",  64'(bus.in_ready),  64'd1);
    check_val("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("reset_done",      64'(done),          64'd0);
    check_val("reset_count",     64'(count),         64'd0);
    rst_n = 1'b1;

    // basic in-order pass-through
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, mk(i));
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // fill past full, then release
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(100 + i));
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // steady occupancy of 8 with concurrent push/pop across the wrap
    for (int i = 0; i < 8; i++)  cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(200 + i));
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, mk(210 + i));
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // drain with 3 entries and a coincident tuple on stop
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(300 + i));
    cycle(1'b1, 1'b0, 1'b1, 1'b0, mk(399));
    for (int i = 0; i < 20 && m_phase != P_DONE; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, mk(398));
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, mk(400));
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // drain entered empty
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // reset mid-stream
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(500 + i));
    reset_mid();
    cycle(1'b1, 1'b1, 1'b0, 1'b0, mk(777));
    repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // randomized traffic including sporadic stop/start
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 500) % 3;
      cycle(1'($urandom_range(0, 1)),
            (bias == 0) ? 1'($urandom_range(0, 3) != 0) :
            (bias == 1) ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 79) == 0),
            1'($urandom_range(0, 5) == 0),
            rnd_tup());
    end

`ifdef TRANSITION_BUFFER_STATS_EN
    reset_mid();
    for (int i = 0; i < 300; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, rnd_tup());
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    @(negedge clk);
    #1;
    check_val("acc_300", 64'(acc_cnt), 64'd300);
    check_val("del_300", 64'(del_cnt), 64'd300);
    for (int i = 0; i < 70000; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, rnd_tup());
    @(negedge clk);
    #1;
    check_val("acc_sat", 64'(acc_cnt), 64'hFFFF);
    check_val("del_sat", 64'(del_cnt), 64'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/transition_buffer.md
# transition_buffer

Synthesizable, parametrised buffer for Q-learning transition tuples (state, next_state, action, reward) feeding the Q-update pipeline. Accepts tuples from any producer (loader, environment model, testbench driver) over a valid/ready handshake and stores them in a DEPTH-entry FIFO. Presents them downstream as first-word-fall-through with a valid/ready handshake. A stop/drain/done state machine gives an orderly end-of-episode signal.

## Interface
- STATES_WIDTH, 8, width of state and next_state fields
- ACTIONS_WIDTH, 2, width of action field
- DATA_WIDTH, 16, width of reward field (two's complement, passed through untouched)
- DEPTH, 16, FIFO entries; power of two, >= 2
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived, not overridden)

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a tuple
- in_ready  out  1  buffer can accept; transfer when in_valid && in_ready
- in_state, in_next_state  in  STATES_WIDTH  tuple fields
- in_action  in  ACTIONS_WIDTH  tuple field
- in_reward  in  DATA_WIDTH  tuple field
- out_valid  out  1  head tuple available
- out_ready  in  1  consumer takes head; transfer when out_valid && out_ready
- out_state, out_next_state, out_action, out_reward  out  as inputs  head tuple
- stop  in  1  end of input stream (level or pulse)
- start  in  1  re-arm after done (pulse)
- done  out  1  stream stopped and fully drained
- count  out  ADDR_WIDTH+1  entries held, 0..DEPTH

## Operation
- States: RUN, DRAIN, DONE. Reset state is RUN.
- RUN:
  - in_ready = (count != DEPTH) && !stop.
  - stop → DRAIN next cycle.
  - start is ignored.
- DRAIN:
  - in_ready = 0; the consumer continues to pop.
  - Goes to DONE on the cycle after registered count == 0. If count is already 0 on entry, DONE follows one cycle later.
- DONE:
  - in_ready = 0, done = 1.
  - start → RUN; stop is ignored; FIFO is empty.
- stop and in_valid in the same RUN cycle: stop wins and that tuple is not accepted.
- Storage:
  - Packed tuple memory of DEPTH entries, with write pointer and read pointer of ADDR_WIDTH bits each. Pointers wrap modulo DEPTH.
  - Occupancy is tracked in count.
- Push when full is impossible: in_ready is low when full, independent of out_ready. No pop-and-push bypass at full.
- Pop when empty is impossible: out_valid = (count != 0). There is no combinational in→out bypass.
- Simultaneous push and pop when not full and not empty: count is unchanged and both pointers advance.
- out_* is driven from the memory at the read pointer. The value is undefined while out_valid = 0; the bench must not check it then.
- Tuples leave in exact arrival order, with no modification.

## Timing
- Reset values:
  - in_ready = 1.
  - out_valid = 0, done = 0, count = 0.
  - Pointers = 0, state = RUN.
  - Memory contents are not reset.
- Reset asserted mid-stream discards all entries immediately (asynchronous reset).
- Latency: a tuple accepted at edge N is visible with out_valid = 1 after edge N (same cycle as count = 1).
- Throughput: one push and one pop per cycle sustained.
- done rises exactly one cycle after count reaches 0 in DRAIN. done falls the cycle after start is sampled.
- count updates on the edge of the handshake.

## Configuration
- TRANSITION_BUFFER_STATS_EN defined: adds two outputs.
  - accepted_cnt  out  16: input handshakes.
  - delivered_cnt  out  16: output handshakes.
  - Both counters saturate at 16'hFFFF, reset to 0 on rst_n, and clear on start in DONE.
- Not defined: the ports and counters are absent and all other behaviour is identical.

## Test plan
- Basic order: push 5 tuples (state=i, next_state=i+1, action=i%4, reward=-i) with out_ready=1 → identical 5 tuples out in order, one cycle after each push; count never exceeds 1.
- Full: DEPTH=16, out_ready=0, push 20 → in_ready drops after 16 accepts, count=16. Release out_ready → 16 tuples out, in_ready returns the cycle after the first pop.
- Concurrent: count=8, in_valid=out_ready=1 for 10 cycles → count stays 8, all pointers wrap past 15 correctly.
- Drain: count=3, stop pulse with in_valid=1 → that tuple is not accepted, 3 pops, done=1 one cycle after count=0. start → done=0, in_ready=1.
- Reset mid-stream: count=6, rst_n low → out_valid=0, count=0 at once. After release, a new push is delivered and no old data appears.
- Stats (macro on): 300 pushes and pops → accepted_cnt=delivered_cnt=300. Force 70000 → counters hold 65535.
